uart_receiver_baudrate: RTL and testbench

Serial receive stage that sits directly downstream of the transmitter's Txo line and recovers 11-bit frames from it. Frame format: start (0), 8 data bits LSB-first, even-parity bit (parity = XOR of data), stop (1); line idles high. It uses the same BC baud-select encoding as the transmitter, so a matched pair runs at the same rate. It presents each byte with a one-cycle valid strobe and per-frame parity/framing error flags.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_baud_counter.sv | 34 +++
 rtl/uart_receiver_baudrate.sv | 150 +++++++++++++++
 tb/tb_uart_receiver_baudrate.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select codes, divisor table, receiver states, frame constants.
package uart_pkg;

    localparam int unsigned CNT_W     = 9;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned BC_W      = 3;

    localparam logic [BC_W-1:0] BC_217 = 3'b001;
    localparam logic [BC_W-1:0] BC_109 = 3'b010;
    localparam logic [BC_W-1:0] BC_72  = 3'b011;
    localparam logic [BC_W-1:0] BC_36  = 3'b100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Clocks per bit for a baud-select code; unlisted codes fall back to the slowest rate.
    function automatic logic [CNT_W-1:0] baud_div(input logic [BC_W-1:0] bc);
        case (bc)
            BC_217:  return CNT_W'(217);
            BC_109:  return CNT_W'(109);
            BC_72:   return CNT_W'(72);
            BC_36:   return CNT_W'(36);
            default: return CNT_W'(434);
        endcase
    endfunction

    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: ticks at div-1 (full bit) or floor(div/2)-1 (half bit), then reloads to 0.
module uart_baud_counter
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] div,
    input  logic             clr,
    input  logic             half_sel,
    output logic             tick_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] target_c;

    always_comb begin
        target_c = half_sel ? ((div >> 1) - CNT_W'(1)) : (div - CNT_W'(1));
        tick_c   = (cnt_q == target_c);
        cnt_d    = cnt_q + CNT_W'(1);
        if (clr || tick_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_receiver_baudrate.sv
// UART receive stage: synchronises Rxi, recovers start/8 data/[parity]/stop frames, flags errors.
module uart_receiver_baudrate
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          PARITY_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] BC,
    input  logic       Rxi,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    rx_state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0]       div_q, div_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   p_s_q, p_s_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q, busy_d;

    logic rx_s;
    logic fall_c;
    logic tick_c;
    logic cnt_clr_c;
    logic half_sel_c;

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign fall_c = rx_prev_q & ~rx_s;

    uart_baud_counter u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .div     (div_q),
        .clr     (cnt_clr_c),
        .half_sel(half_sel_c),
        .tick_c  (tick_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fall_c) state_d = START;
            START:   if (tick_c) state_d = rx_s ? IDLE : DATA;
            DATA:    if (tick_c && (idx_q == IDX_W'(DATA_BITS - 1)))
                         state_d = PARITY_EN ? PARITY : STOP;
            PARITY:  if (tick_c) state_d = STOP;
            STOP:    if (tick_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs; the counter is held clear while idle.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], Rxi};
        rx_prev_d  = rx_s;
        div_d      = div_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        p_s_d      = p_s_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        busy_d     = (state_d != IDLE);
        cnt_clr_c  = 1'b0;
        half_sel_c = (state_q == START);
        case (state_q)
            IDLE: begin
                cnt_clr_c = 1'b1;
                if (fall_c) div_d = baud_div(BC);
            end
            START: begin
                if (tick_c) idx_d = '0;
            end
            DATA: begin
                if (tick_c) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            PARITY: begin
                if (tick_c) p_s_d = rx_s;
            end
            STOP: begin
                if (tick_c) begin
                    data_d  = shift_q;
                    ferr_d  = ~rx_s;
                    perr_d  = PARITY_EN & (p_s_q ^ even_parity(shift_q));
                    valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
            div_q     <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            p_s_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            rx_prev_q <= rx_prev_d;
            div_q     <= div_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            p_s_q     <= p_s_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign RxData     = data_q;
    assign RxValid    = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_receiver_baudrate.sv
// Directed bench for uart_receiver_baudrate: drives serial frames and checks captured strobes.
module tb_uart_receiver_baudrate;

    logic       clk;
    logic       rst_n;
    logic [2:0] BC;
    logic       Rxi;
    logic [7:0] RxData;
    logic       RxValid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cycle     = 0;
    int edge_cyc  = 0;

    int         cap_cnt = 0;
    int         cap_cyc = 0;
    logic [7:0] cap_data [0:15];
    logic       cap_perr [0:15];
    logic       cap_ferr [0:15];

    uart_receiver_baudrate #(.SYNC_STAGES(2), .PARITY_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .BC        (BC),
        .Rxi       (Rxi),
        .RxData    (RxData),
        .RxValid   (RxValid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (rst_n && RxValid) begin
            if (cap_cnt < 16) begin
                cap_data[cap_cnt] = RxData;
                cap_perr[cap_cnt] = parity_err;
                cap_ferr[cap_cnt] = frame_err;
            end
            cap_cyc = cycle;
            cap_cnt = cap_cnt + 1;
        end
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish within 60000 cycles");
        $fatal(1);
    end

    function automatic int bench_div(input logic [2:0] bc);
        case (bc)
            3'b001:  return 217;
            3'b010:  return 109;
            3'b011:  return 72;
            3'b100:  return 36;
            default: return 434;
        endcase
    endfunction

    task automatic send_bit(input logic b, input int div);
        Rxi = b;
        repeat (div) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int div);
        edge_cyc = cycle;
        send_bit(1'b0, div);
        for (int i = 0; i < 8; i++) send_bit(d[i], div);
        send_bit(p, div);
        send_bit(s, div);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        Rxi   = 1'b1;
        BC    = 3'b000;
        repeat (3) @(negedge clk);
        total_cnt++; if (RxData !== 8'h00) $display("FAIL reset_data got=%h exp=00", RxData); else pass_cnt++;
        total_cnt++; if (RxValid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", RxValid); else pass_cnt++;
        total_cnt++; if (parity_err !== 1'b0) $display("FAIL reset_perr got=%b exp=0", parity_err); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_ferr got=%b exp=0", frame_err); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_basic();
        int base;
        int lat;
        base = cap_cnt;
        BC = 3'b000;
        send_frame(8'h0B, 1'b1, 1'b1, bench_div(BC));
        repeat (20) @(negedge clk);
        lat = cap_cyc - edge_cyc;
        total_cnt++; if (cap_cnt !== base + 1) $display("FAIL basic_count got=%0d exp=%0d", cap_cnt - base, 1); else pass_cnt++;
        total_cnt++; if (cap_data[base] !== 8'h0B) $display("FAIL basic_data got=%h exp=0b", cap_data[base]); else pass_cnt++;
        total_cnt++; if (cap_perr[base] !== 1'b0) $display("FAIL basic_perr got=%b exp=0", cap_perr[base]); else pass_cnt++;
        total_cnt++; if (cap_ferr[base] !== 1'b0) $display("FAIL basic_ferr got=%b exp=0", cap_ferr[base]); else pass_cnt++;
        total_cnt++; if (lat < 4558 || lat > 4562) $display("FAIL basic_latency got=%0d exp=4560+-2", lat); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_idle got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int base;
        base = cap_cnt;
        BC = 3'b001;
        send_frame(8'h0F, 1'b0, 1'b1, bench_div(BC));
        send_frame(8'hE8, 1'b0, 1'b1, bench_div(BC));
        repeat (20) @(negedge clk);
        total_cnt++; if (cap_cnt !== base + 2) $display("FAIL b2b_count got=%0d exp=2", cap_cnt - base); else pass_cnt++;
        total_cnt++; if (cap_data[base] !== 8'h0F) $display("FAIL b2b_data0 got=%h exp=0f", cap_data[base]); else pass_cnt++;
        total_cnt++; if (cap_data[base+1] !== 8'hE8) $display("FAIL b2b_data1 got=%h exp=e8", cap_data[base+1]); else pass_cnt++;
        total_cnt++; if ({cap_perr[base], cap_ferr[base], cap_perr[base+1], cap_ferr[base+1]} !== 4'b0000)
            $display("FAIL b2b_flags got=%b%b%b%b exp=0000", cap_perr[base], cap_ferr[base], cap_perr[base+1], cap_ferr[base+1]);
        else pass_cnt++;
    endtask

    task automatic test_parity_err();
        int base;
        base = cap_cnt;
        BC = 3'b011;
        send_frame(8'h6F, 1'b1, 1'b1, bench_div(BC));
        repeat (10) @(negedge clk);
        total_cnt++; if (cap_data[base] !== 8'h6F) $display("FAIL perr_data got=%h exp=6f", cap_data[base]); else pass_cnt++;
        total_cnt++; if (cap_perr[base] !== 1'b1) $display("FAIL perr_flag got=%b exp=1", cap_perr[base]); else pass_cnt++;
        total_cnt++; if (cap_ferr[base] !== 1'b0) $display("FAIL perr_ferr got=%b exp=0", cap_ferr[base]); else pass_cnt++;
        total_cnt++; if (parity_err !== 1'b1) $display("FAIL perr_hold got=%b exp=1", parity_err); else pass_cnt++;
        BC = 3'b100;
        send_frame(8'h09, 1'b0, 1'b1, bench_div(BC));
        repeat (10) @(negedge clk);
        total_cnt++; if (cap_cnt !== base + 2) $display("FAIL perr_count got=%0d exp=2", cap_cnt - base); else pass_cnt++;
        total_cnt++; if (cap_data[base+1] !== 8'h09) $display("FAIL perr_next_data got=%h exp=09", cap_data[base+1]); else pass_cnt++;
        total_cnt++; if ({parity_err, frame_err} !== 2'b00) $display("FAIL perr_clear got=%b%b exp=00", parity_err, frame_err); else pass_cnt++;
    endtask

    task automatic test_frame_err();
        int base;
        base = cap_cnt;
        BC = 3'b000;
        send_frame(8'h00, 1'b0, 1'b0, bench_div(BC));
        repeat (3 * 434) @(negedge clk);
        total_cnt++; if (cap_cnt !== base + 1) $display("FAIL ferr_count got=%0d exp=1", cap_cnt - base); else pass_cnt++;
        total_cnt++; if (cap_data[base] !== 8'h00) $display("FAIL ferr_data got=%h exp=00", cap_data[base]); else pass_cnt++;
        total_cnt++; if (cap_ferr[base] !== 1'b1) $display("FAIL ferr_flag got=%b exp=1", cap_ferr[base]); else pass_cnt++;
        total_cnt++; if (cap_perr[base] !== 1'b0) $display("FAIL ferr_perr got=%b exp=0", cap_perr[base]); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL ferr_stuck_low_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b1) $display("FAIL ferr_hold got=%b exp=1", frame_err); else pass_cnt++;
        Rxi = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_glitch();
        int base;
        base = cap_cnt;
        BC = 3'b000;
        Rxi = 1'b0;
        repeat (50) @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL glitch_busy_high got=%b exp=1", busy); else pass_cnt++;
        repeat (50) @(negedge clk);
        Rxi = 1'b1;
        repeat (125) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy_low got=%b exp=0", busy); else pass_cnt++;
        repeat (500) @(negedge clk);
        total_cnt++; if (cap_cnt !== base) $display("FAIL glitch_no_valid got=%0d exp=0", cap_cnt - base); else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        int          base;
        int          div;
        logic [7:0]  d;
        base = cap_cnt;
        BC   = 3'b001;
        div  = bench_div(BC);
        d    = 8'hA5;
        send_bit(1'b0, div);
        for (int i = 0; i < 4; i++) send_bit(d[i], div);
        send_bit(d[4], div / 2);
        rst_n = 1'b0;
        Rxi   = 1'b1;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL midrst_ferr got=%b exp=0", frame_err); else pass_cnt++;
        total_cnt++; if ({RxData, RxValid, parity_err} !== 10'h000) $display("FAIL midrst_outputs got=%h,%b,%b exp=00,0,0", RxData, RxValid, parity_err); else pass_cnt++;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * div) @(negedge clk);
        total_cnt++; if (cap_cnt !== base) $display("FAIL midrst_discard got=%0d exp=0", cap_cnt - base); else pass_cnt++;
        send_frame(8'h3C, 1'b0, 1'b1, div);
        repeat (10) @(negedge clk);
        total_cnt++; if (cap_cnt !== base + 1) $display("FAIL midrst_count got=%0d exp=1", cap_cnt - base); else pass_cnt++;
        total_cnt++; if (cap_data[base] !== 8'h3C) $display("FAIL midrst_data got=%h exp=3c", cap_data[base]); else pass_cnt++;
        total_cnt++; if ({cap_perr[base], cap_ferr[base]} !== 2'b00) $display("FAIL midrst_flags got=%b%b exp=00", cap_perr[base], cap_ferr[base]); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        Rxi   = 1'b1;
        BC    = 3'b000;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_parity_err();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
